// File: rtl/pc_fetch_unit.sv
// Fetch PC register and sequencer: reset, exception entry, eret, redirect buffering while stalled.
// Define PC_FETCH_RANGE_CHECK_EN to add the IMEM_BASE/IMEM_LIMIT range check to fetch_exc.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter logic [31:0] EXC_HANDLER = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IMEM_LIMIT  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_enter,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect_pending,
    output logic        fetch_exc,
    output logic [4:0]  exc_code
);

    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        misaligned;
    logic        out_of_range;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d      = pc_plus4;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (exc_enter) begin
            pc_d   = EXC_HANDLER;
            pend_d = 1'b0;
        end else if (eret) begin
            pc_d   = epc;
            pend_d = 1'b0;
        end else if (stall) begin
            // Hold F; remember only the newest redirect seen during the stall.
            pc_d = pc_q;
            if (redirect_valid) begin
                pend_d    = 1'b1;
                pend_pc_d = redirect_pc;
            end
        end else if (redirect_valid) begin
            pc_d   = redirect_pc;
            pend_d = 1'b0;
        end else if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign misaligned = (pc_q[1:0] != 2'b00);

`ifdef PC_FETCH_RANGE_CHECK_EN
    assign out_of_range = (pc_q < IMEM_BASE) || (pc_q > IMEM_LIMIT);
`else
    assign out_of_range = 1'b0;
`endif

    assign pc               = pc_q;
    assign redirect_pending = pend_q;
    assign fetch_exc        = misaligned || out_of_range;
    assign exc_code         = fetch_exc ? EXC_ADEL : 5'd0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed plan with literal pins, then randomized traffic vs. a reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
    localparam logic [31:0] IMEM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IMEM_LIMIT  = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, exc_enter, eret;
    logic [31:0] redirect_pc, epc;
    logic [31:0] pc, pc_plus4;
    logic        redirect_pending, fetch_exc;
    logic [4:0]  exc_code;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: the architectural PC and a one-deep "deferred redirect" slot.
    logic [31:0] m_pc = 32'd0;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'd0;

    pc_fetch_unit #(
        .RESET_PC(RESET_PC), .EXC_HANDLER(EXC_HANDLER),
        .IMEM_BASE(IMEM_BASE), .IMEM_LIMIT(IMEM_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc_enter(exc_enter), .eret(eret), .epc(epc),
        .pc(pc), .pc_plus4(pc_plus4), .redirect_pending(redirect_pending),
        .fetch_exc(fetch_exc), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    function automatic logic exp_exc(input logic [31:0] a);
        logic bad;
        bad = (a % 4) != 0;
`ifdef PC_FETCH_RANGE_CHECK_EN
        if (a < IMEM_BASE || a > IMEM_LIMIT) bad = 1'b1;
`endif
        return bad;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock: model takes the same edge, then all outputs compared mid-cycle.
    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            m_pc = RESET_PC; m_pend = 1'b0; m_pend_pc = 32'd0;
        end else if (exc_enter) begin
            m_pc = EXC_HANDLER; m_pend = 1'b0;
        end else if (eret) begin
            m_pc = epc; m_pend = 1'b0;
        end else if (stall) begin
            if (redirect_valid) begin
                m_pend = 1'b1; m_pend_pc = redirect_pc;
            end
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc = m_pend_pc; m_pend = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
        chk("fetch_exc", {31'd0, fetch_exc}, {31'd0, exp_exc(m_pc)});
        chk("exc_code", {27'd0, exc_code}, exp_exc(m_pc) ? 32'd4 : 32'd0);
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; exc_enter = 1'b0; eret = 1'b0;
    endtask

    logic [31:0] targets [8];

    initial begin
        idle();
        redirect_pc = 32'd0; epc = 32'd0;
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_pc_plus4", pc_plus4, 32'h3004);
        chk("rst_pending", {31'd0, redirect_pending}, 32'd0);
        chk("rst_fetch_exc", {31'd0, fetch_exc}, 32'd0);
        chk("rst_exc_code", {27'd0, exc_code}, 32'd0);

        cyc(); chk("run_3004", pc, 32'h3004);
        cyc(); chk("run_3008", pc, 32'h3008);
        cyc(); chk("run_300c", pc, 32'h300C);
        chk("run_fetch_exc", {31'd0, fetch_exc}, 32'd0);
        cyc(); chk("run_3010", pc, 32'h3010);

        redirect_valid = 1'b1; redirect_pc = 32'h3400;
        cyc(); redirect_valid = 1'b0;
        chk("redir_pc", pc, 32'h3400);
        chk("redir_plus4", pc_plus4, 32'h3404);

        redirect_valid = 1'b1; redirect_pc = 32'h3020;
        cyc();
        stall = 1'b1; redirect_pc = 32'h3100;
        cyc(); redirect_valid = 1'b0;
        chk("stall_hold1", pc, 32'h3020);
        chk("stall_pend1", {31'd0, redirect_pending}, 32'd1);
        cyc();
        chk("stall_hold2", pc, 32'h3020);
        chk("stall_pend2", {31'd0, redirect_pending}, 32'd1);
        stall = 1'b0;
        cyc();
        chk("release_pc", pc, 32'h3100);
        chk("release_pend", {31'd0, redirect_pending}, 32'd0);

        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3100;
        cyc(); redirect_valid = 1'b0;
        chk("exc_pre_pend", {31'd0, redirect_pending}, 32'd1);
        exc_enter = 1'b1;
        cyc(); exc_enter = 1'b0;
        chk("exc_pc", pc, 32'h4180);
        chk("exc_pend", {31'd0, redirect_pending}, 32'd0);
        eret = 1'b1; epc = 32'h3024;
        cyc(); eret = 1'b0; stall = 1'b0;
        chk("eret_pc", pc, 32'h3024);

        redirect_valid = 1'b1; redirect_pc = 32'h3002;
        cyc();
        chk("misalign_exc", {31'd0, fetch_exc}, 32'd1);
        chk("misalign_code", {27'd0, exc_code}, 32'd4);
        redirect_pc = 32'h7000;
        cyc();
`ifdef PC_FETCH_RANGE_CHECK_EN
        chk("range_exc", {31'd0, fetch_exc}, 32'd1);
`else
        chk("range_exc", {31'd0, fetch_exc}, 32'd0);
`endif
        redirect_pc = 32'hFFFF_FFFC;
        cyc(); redirect_valid = 1'b0;
        chk("wrap_plus4", pc_plus4, 32'h0);
        cyc();
        chk("wrap_pc", pc, 32'h0);

        exc_enter = 1'b1; eret = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3400;
        cyc(); idle();
        chk("all_req_pc", pc, 32'h4180);
        reset = 1'b1; exc_enter = 1'b1;
        cyc(); idle();
        chk("rst_vs_exc_pc", pc, 32'h3000);

        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3500;
        cyc(); redirect_valid = 1'b0; reset = 1'b1;
        cyc(); idle();
        chk("rst_drop_pc", pc, 32'h3000);
        chk("rst_drop_pend", {31'd0, redirect_pending}, 32'd0);

        targets[0] = 32'h3000; targets[1] = 32'h6FFC; targets[2] = 32'h7000;
        targets[3] = 32'h2FFC; targets[4] = 32'h3002; targets[5] = 32'hFFFF_FFFC;
        targets[6] = 32'h4180; targets[7] = 32'h5001;
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            stall          = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 3) == 0);
            exc_enter      = ($urandom_range(0, 19) == 0);
            eret           = ($urandom_range(0, 14) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 0) ? targets[$urandom_range(0, 7)]
                                                         : $urandom;
            epc            = ($urandom_range(0, 1) == 0) ? targets[$urandom_range(0, 7)]
                                                         : $urandom;
            cyc();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
